gmii_rx_frame_ctrl: RTL and testbench
=====================================

# gmii_rx_frame_ctrl

Receive frame controller placed directly after the 100M RGMII-to-GMII receive stage. It consumes the GMII byte stream (`gmii_rx_dv`/`gmii_rxd`), strips preamble and SFD, and delimits each frame with SOF/EOF. It enforces minimum and maximum frame length, optionally checks the FCS, and keeps good/bad frame statistics for the TRDP MAC layer. Output is a per-byte strobe stream plus a per-frame status pulse.

## Interface
- `BYTE_DIV`, 2: clock cycles per byte. 2 for the 100M path, where each byte is held for 2 cycles; 1 for 1G.
- `MIN_LEN`, 64: minimum frame length in bytes, DA through FCS inclusive.
- `MAX_LEN`, 1518: maximum frame length in bytes, DA through FCS inclusive.
- `eth_rxc_sample` in 1: receive sample clock. This is the only clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `gmii_rx_dv` in 1: GMII data valid from the receive stage.
- `gmii_rxd` in 8: GMII byte from the receive stage.
- `rx_data` out 8: frame byte (DA through FCS).
- `rx_valid` out 1: one-cycle strobe, `rx_data` is valid.
- `rx_sof` out 1: asserted with the first `rx_valid` of a frame.
- `rx_eof` out 1: asserted with the last `rx_valid` of a frame.
- `rx_err` out 1: frame error. Meaningful only when `rx_eof` or `frame_done` is high.
- `frame_done` out 1: one-cycle pulse at frame end.
- `rx_len` out 16: byte count of the last frame. Updated with `frame_done`.
- `cnt_good` out 16: saturating count of good frames.
- `cnt_bad` out 16: saturating count of bad frames.

## Operation
- **Byte sampling.** A byte is taken on the first cycle `gmii_rx_dv` is high, then every `BYTE_DIV` cycles while it stays high. A phase counter resets whenever `gmii_rx_dv` is low.
- **FSM states:** IDLE, PREAMBLE, DATA, DROP.
- **IDLE**
  - `gmii_rx_dv` rising with a 0x55 byte -> PREAMBLE.
  - Any other first byte -> DROP.
- **PREAMBLE**
  - 0x55 -> stay. Accept 1 to 7 bytes of 0x55 in total.
  - 0xD5 after at least one 0x55 -> DATA.
  - Any other byte, or an 8th 0x55 -> DROP, counted bad.
  - `gmii_rx_dv` low -> IDLE, counted bad, with a `frame_done` pulse (`rx_err`=1, `rx_len`=0).
- **DATA**
  - Each byte goes into a one-byte hold register. When the next byte arrives, the held byte is emitted with `rx_valid` (`rx_sof` on the first).
  - Length counter increments per byte and saturates at 0xFFFF.
- **Frame end** (`gmii_rx_dv` falls in DATA):
  - Next cycle: emit the held byte with `rx_valid`, `rx_eof`, `rx_err`, `frame_done`; `rx_len` is loaded; return to IDLE.
  - `rx_err` = (len < `MIN_LEN`) or FCS bad (only when FCS checking is compiled in).
  - Zero-length frame (`gmii_rx_dv` falls right after SFD): no `rx_valid` and no `rx_eof`; `frame_done` with `rx_err`=1, `rx_len`=0; counted bad.
- **Overlength.**
  - On byte `MAX_LEN`+1: that byte is not captured. The held byte (byte `MAX_LEN`) is emitted with `rx_eof`=1, `rx_err`=1, `frame_done`=1, and `rx_len`=`MAX_LEN`.
  - The FSM then enters DROP.
- **DROP.** Ignore everything until `gmii_rx_dv` is low, then IDLE. No outputs are produced.
- **Counters.** `cnt_good`/`cnt_bad` increment once per `frame_done` according to `rx_err`, and saturate at 0xFFFF.
- **Reset (`rst_n` low, any time, including mid-frame):**
  - All outputs go to 0, FSM to IDLE, counters to 0.
  - No EOF is emitted for a frame cut off by reset.

## Timing
- Reset value of every output: 0.
- Latency: a byte appears on `rx_data` one byte period (`BYTE_DIV` cycles) after it is sampled. The last byte appears 1 cycle after `gmii_rx_dv` falls.
- `rx_valid`, `rx_sof`, `rx_eof` and `frame_done` are single-cycle pulses. `rx_data` holds its value between strobes.
- A `gmii_rx_dv` rise in the cycle immediately after a frame-end cycle starts a new frame normally; back-to-back frames need no inter-frame gap cycles.
- `rx_len` and `rx_err` are stable from `frame_done` until the next `frame_done`.

## Configuration
- `RX_FCS_CHECK_EN` defined:
  - CRC32 is computed over every DATA byte, including the FCS: reflected polynomial 0xEDB88320, init 0xFFFFFFFF.
  - The frame is good only if the register equals 0xDEBB20E3 at frame end.
- Undefined: no CRC logic; `rx_err` reflects length checks only.

## Structure
- **Package `eth_rx_pkg`** contains:
  - the FSM state enum;
  - preamble 0x55 and SFD 0xD5 constants;
  - the max preamble count of 7;
  - the CRC polynomial, init and residue constants.
- **Sub-module `eth_crc32_d8`:** byte-wide CRC update with inputs clk, rst_n, init, en, data[7:0] and output crc[31:0]. It is instantiated only under `RX_FCS_CHECK_EN`.

## Test plan
- **Good 64-byte frame:** 7x55, D5, 60 payload + valid FCS, `BYTE_DIV`=2 -> 64 `rx_valid` pulses, SOF on byte 0, EOF on byte 63, `rx_err`=0, `rx_len`=64, `cnt_good`=1.
- **Runt frame:** good preamble, 40 bytes -> EOF on byte 39, `rx_err`=1, `rx_len`=40, `cnt_bad`=1.
- **FCS corrupted:** 64-byte frame with one payload bit flipped -> `rx_err`=1 with `RX_FCS_CHECK_EN`, 0 without.
- **Overlength frame:** 1600 bytes -> EOF on byte 1517, `rx_err`=1, `rx_len`=1518; remaining bytes produce no `rx_valid`; the next good frame is received normally.
- **Bad preamble:** 55 55 A3 ... -> no `rx_valid`, `cnt_bad`+1. Then `gmii_rx_dv` low for 1 cycle followed by a good frame -> accepted.
- **Reset mid-frame:** `rst_n` pulsed low at byte 20 -> outputs 0 immediately, no EOF, counters 0, next frame accepted.

Source files
------------

// File: rtl/eth_rx_pkg.sv
// eth_rx_pkg: shared FSM states, preamble/SFD bytes and CRC32 constants for the GMII receive path.
package eth_rx_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_PREAMBLE, ST_DATA, ST_DROP} rx_state_e;
    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam int          MAX_PREAMBLE  = 7;
    localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;
    function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
        return r;
    endfunction
endpackage

// File: rtl/eth_crc32_d8.sv
// eth_crc32_d8: byte-wide reflected CRC32 register, no final inversion (good frame leaves the residue).
module eth_crc32_d8
    import eth_rx_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [31:0] crc
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) crc <= CRC_INIT;
        else if (init) crc <= CRC_INIT;
        else if (en) crc <= crc32_byte(crc, data);
    end
endmodule

// File: rtl/gmii_rx_frame_ctrl.sv
// gmii_rx_frame_ctrl: strips preamble/SFD, delimits frames, enforces length limits, keeps statistics.
// Defining RX_FCS_CHECK_EN adds the CRC32 FCS check to the frame error.
module gmii_rx_frame_ctrl
    import eth_rx_pkg::*;
#(
    parameter int BYTE_DIV = 2,
    parameter int MIN_LEN  = 64,
    parameter int MAX_LEN  = 1518
) (
    input  logic        eth_rxc_sample,
    input  logic        rst_n,
    input  logic        gmii_rx_dv,
    input  logic [7:0]  gmii_rxd,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        rx_sof,
    output logic        rx_eof,
    output logic        rx_err,
    output logic        frame_done,
    output logic [15:0] rx_len,
    output logic [15:0] cnt_good,
    output logic [15:0] cnt_bad
);
    rx_state_e   st_q, st_d;
    logic [7:0]  ph_q, ph_d, hold_q, hold_d, data_q, data_d;
    logic [2:0]  pre_q, pre_d;
    logic [15:0] len_q, len_d, rlen_q, rlen_d, good_q, bad_q;
    logic        dv_q, have_q, have_d, first_q, first_d;
    logic        valid_q, valid_d, sof_q, sof_d, eof_q, eof_d, err_q, err_d, done_q, done_d;
    logic        good_inc, bad_inc, take, fcs_bad;

    assign take = gmii_rx_dv && ph_q == 8'd0;
    assign ph_d = (!gmii_rx_dv || ph_q == 8'(BYTE_DIV - 1)) ? 8'd0 : ph_q + 8'd1;

`ifdef RX_FCS_CHECK_EN
    logic [31:0] crc;
    eth_crc32_d8 u_crc (
        .clk  (eth_rxc_sample),
        .rst_n(rst_n),
        .init (st_q == ST_PREAMBLE && take && gmii_rxd == SFD_BYTE),
        .en   (st_q == ST_DATA && take && len_q != 16'(MAX_LEN)),
        .data (gmii_rxd),
        .crc  (crc)
    );
    assign fcs_bad = crc != CRC_RESIDUE;
`else
    assign fcs_bad = 1'b0;
`endif

    always_comb begin
        st_d = st_q;
        pre_d = pre_q;
        len_d = len_q;
        hold_d = hold_q;
        have_d = have_q;
        first_d = first_q;
        data_d = data_q;
        valid_d = 1'b0;
        sof_d = 1'b0;
        eof_d = 1'b0;
        done_d = 1'b0;
        err_d = err_q;
        rlen_d = rlen_q;
        good_inc = 1'b0;
        bad_inc = 1'b0;
        case (st_q)
            ST_IDLE: if (gmii_rx_dv) begin
                // dv already high on entry (e.g. released from reset mid-frame) is not a frame start
                st_d = (dv_q || gmii_rxd != PREAMBLE_BYTE) ? ST_DROP : ST_PREAMBLE;
                pre_d = 3'd1;
            end
            ST_PREAMBLE: if (!gmii_rx_dv) begin
                st_d = ST_IDLE;
                done_d = 1'b1;
                err_d = 1'b1;
                rlen_d = 16'd0;
                bad_inc = 1'b1;
            end else if (take) begin
                if (gmii_rxd == SFD_BYTE) begin
                    st_d = ST_DATA;
                    len_d = 16'd0;
                    have_d = 1'b0;
                    first_d = 1'b1;
                end else if (gmii_rxd == PREAMBLE_BYTE && pre_q < 3'(MAX_PREAMBLE)) begin
                    pre_d = pre_q + 3'd1;
                end else begin
                    st_d = ST_DROP;
                    bad_inc = 1'b1;
                end
            end
            ST_DATA: if (!gmii_rx_dv) begin
                st_d = ST_IDLE;
                done_d = 1'b1;
                valid_d = have_q;
                sof_d = have_q && first_q;
                eof_d = have_q;
                data_d = have_q ? hold_q : data_q;
                err_d = !have_q || len_q < 16'(MIN_LEN) || fcs_bad;
                rlen_d = len_q;
                good_inc = !err_d;
                bad_inc = err_d;
            end else if (take) begin
                if (len_q == 16'(MAX_LEN)) begin
                    st_d = ST_DROP;
                    valid_d = 1'b1;
                    sof_d = first_q;
                    eof_d = 1'b1;
                    data_d = hold_q;
                    err_d = 1'b1;
                    done_d = 1'b1;
                    rlen_d = len_q;
                    bad_inc = 1'b1;
                end else begin
                    valid_d = have_q;
                    sof_d = have_q && first_q;
                    first_d = first_q && !have_q;
                    data_d = have_q ? hold_q : data_q;
                    hold_d = gmii_rxd;
                    have_d = 1'b1;
                    len_d = (len_q == 16'hFFFF) ? len_q : len_q + 16'd1;
                end
            end
            ST_DROP: if (!gmii_rx_dv) st_d = ST_IDLE;
            default: st_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge eth_rxc_sample or negedge rst_n) begin
        if (!rst_n) begin
            st_q <= ST_IDLE;
            ph_q <= '0;
            dv_q <= 1'b1;
            pre_q <= '0;
            len_q <= '0;
            hold_q <= '0;
            have_q <= 1'b0;
            first_q <= 1'b0;
            data_q <= '0;
            valid_q <= 1'b0;
            sof_q <= 1'b0;
            eof_q <= 1'b0;
            err_q <= 1'b0;
            done_q <= 1'b0;
            rlen_q <= '0;
            good_q <= '0;
            bad_q <= '0;
        end else begin
            st_q <= st_d;
            ph_q <= ph_d;
            dv_q <= gmii_rx_dv;
            pre_q <= pre_d;
            len_q <= len_d;
            hold_q <= hold_d;
            have_q <= have_d;
            first_q <= first_d;
            data_q <= data_d;
            valid_q <= valid_d;
            sof_q <= sof_d;
            eof_q <= eof_d;
            err_q <= err_d;
            done_q <= done_d;
            rlen_q <= rlen_d;
            good_q <= (good_inc && good_q != 16'hFFFF) ? good_q + 16'd1 : good_q;
            bad_q <= (bad_inc && bad_q != 16'hFFFF) ? bad_q + 16'd1 : bad_q;
        end
    end

    assign rx_data = data_q;
    assign rx_valid = valid_q;
    assign rx_sof = sof_q;
    assign rx_eof = eof_q;
    assign rx_err = err_q;
    assign frame_done = done_q;
    assign rx_len = rlen_q;
    assign cnt_good = good_q;
    assign cnt_bad = bad_q;
endmodule

// File: tb/tb_gmii_rx_frame_ctrl.sv
// tb_gmii_rx_frame_ctrl: scoreboard bench; expected bytes and frame status are queued as frames are driven.
module tb_gmii_rx_frame_ctrl;
    localparam int BD = 2, MINL = 64, MAXL = 1518;
`ifdef RX_FCS_CHECK_EN
    localparam bit FCS_EN = 1'b1;
`else
    localparam bit FCS_EN = 1'b0;
`endif
    logic        clk = 1'b0, rst_n = 1'b0, dv = 1'b0;
    logic [7:0]  rxd = 8'h00;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_sof, rx_eof, rx_err, frame_done;
    logic [15:0] rx_len, cnt_good, cnt_bad;

    typedef struct packed {logic [7:0] d; logic sof; logic eof; logic err;} byte_t;
    typedef struct packed {logic err; logic [15:0] len;} stat_t;
    byte_t exp_q[$];
    stat_t sts_q[$];
    byte_t e;
    stat_t s;
    int checks = 0, errors = 0, exp_good = 0, exp_bad = 0;

    gmii_rx_frame_ctrl #(.BYTE_DIV(BD), .MIN_LEN(MINL), .MAX_LEN(MAXL)) dut (
        .eth_rxc_sample(clk), .rst_n(rst_n), .gmii_rx_dv(dv), .gmii_rxd(rxd),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_sof(rx_sof), .rx_eof(rx_eof),
        .rx_err(rx_err), .frame_done(frame_done), .rx_len(rx_len),
        .cnt_good(cnt_good), .cnt_bad(cnt_bad)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    always @(negedge clk) if (rst_n) begin
        if (rx_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL stray_valid got d=%h sof=%b eof=%b want no strobe", rx_data, rx_sof, rx_eof);
            end else begin
                e = exp_q.pop_front();
                if ({rx_data, rx_sof, rx_eof} !== {e.d, e.sof, e.eof} || (e.eof && rx_err !== e.err)) begin
                    errors++;
                    $display("FAIL byte got d=%h sof=%b eof=%b err=%b want d=%h sof=%b eof=%b err=%b",
                             rx_data, rx_sof, rx_eof, rx_err, e.d, e.sof, e.eof, e.err);
                end
            end
        end else if (rx_sof || rx_eof) begin
            checks++;
            errors++;
            $display("FAIL marker_without_valid got sof=%b eof=%b want 0 0", rx_sof, rx_eof);
        end
        if (frame_done) begin
            checks++;
            if (sts_q.size() == 0) begin
                errors++;
                $display("FAIL stray_done got err=%b len=%0d want no frame_done", rx_err, rx_len);
            end else begin
                s = sts_q.pop_front();
                if (rx_err !== s.err || rx_len !== s.len) begin
                    errors++;
                    $display("FAIL status got err=%b len=%0d want err=%b len=%0d", rx_err, rx_len, s.err, s.len);
                end
            end
        end
    end

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    task automatic put(input logic [7:0] b);
        dv = 1'b1;
        rxd = b;
        repeat (BD) @(negedge clk);
    endtask

    task automatic idle(input int n);
        dv = 1'b0;
        rxd = 8'h00;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input int npre, input int n, input bit flip, input int gap);
        logic [7:0] f[$];
        logic [31:0] c;
        int acc;
        bit err;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n - 4; i++) begin
            f.push_back(8'($urandom_range(0, 255)));
            c = crc_upd(c, f[i]);
        end
        c = ~c;
        for (int k = 0; k < 4; k++) f.push_back(c[8*k +: 8]);
        if (flip) f[5] = f[5] ^ 8'h04;
        if (npre >= 1 && npre <= 7) begin
            acc = (n > MAXL) ? MAXL : n;
            err = n < MINL || n > MAXL || (FCS_EN && flip);
            for (int i = 0; i < acc; i++) exp_q.push_back('{f[i], i == 0, i == acc - 1, err});
            sts_q.push_back('{err, 16'(acc)});
            if (err) exp_bad++;
            else exp_good++;
        end else exp_bad++;
        for (int i = 0; i < npre; i++) put(8'h55);
        put(8'hD5);
        foreach (f[i]) put(f[i]);
        idle(gap);
    endtask

    task automatic drain(input string name);
        int t = 0;
        while ((exp_q.size() != 0 || sts_q.size() != 0) && t < 40) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (exp_q.size() != 0 || sts_q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout got pending bytes=%0d status=%0d want 0 0", name, exp_q.size(), sts_q.size());
            exp_q.delete();
            sts_q.delete();
        end
        checks++;
        if (cnt_good !== 16'(exp_good) || cnt_bad !== 16'(exp_bad)) begin
            errors++;
            $display("FAIL %s_counters got good=%0d bad=%0d want good=%0d bad=%0d", name, cnt_good, cnt_bad, exp_good, exp_bad);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({rx_data, rx_valid, rx_sof, rx_eof, rx_err, frame_done, rx_len, cnt_good, cnt_bad} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got d=%h v=%b len=%0d good=%0d bad=%0d want all 0", rx_data, rx_valid, rx_len, cnt_good, cnt_bad);
        end
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_good();
        send_frame(7, 64, 1'b0, 4);
        drain("good64");
        send_frame(1, 65, 1'b0, 4);
        drain("short_preamble");
    endtask

    task automatic test_runt();
        send_frame(7, 40, 1'b0, 4);
        drain("runt");
    endtask

    task automatic test_fcs();
        send_frame(7, 64, 1'b1, 4);
        drain("fcs_flip");
    endtask

    task automatic test_overlength();
        send_frame(7, 1600, 1'b0, 4);
        send_frame(7, 64, 1'b0, 4);
        drain("overlength");
    endtask

    task automatic test_bad_preamble();
        put(8'h55);
        put(8'h55);
        put(8'hA3);
        for (int i = 0; i < 10; i++) put(8'(i * 7 + 1));
        idle(1);
        exp_bad++;
        send_frame(7, 64, 1'b0, 4);
        drain("bad_preamble");
        send_frame(8, 64, 1'b0, 4);
        drain("long_preamble");
    endtask

    task automatic test_short_frames();
        for (int i = 0; i < 7; i++) put(8'h55);
        put(8'hD5);
        sts_q.push_back('{1'b1, 16'd0});
        exp_bad++;
        idle(4);
        drain("zero_len");
        put(8'h55);
        put(8'h55);
        sts_q.push_back('{1'b1, 16'd0});
        exp_bad++;
        idle(4);
        drain("preamble_abort");
    endtask

    task automatic test_back_to_back();
        send_frame(7, 64, 1'b0, 1);
        send_frame(7, 70, 1'b0, 1);
        send_frame(7, 65, 1'b0, 4);
        drain("back_to_back");
    endtask

    task automatic test_reset_mid();
        for (int j = 0; j < 19; j++) exp_q.push_back('{8'(j + 1), j == 0, 1'b0, 1'b0});
        for (int i = 0; i < 7; i++) put(8'h55);
        put(8'hD5);
        for (int j = 0; j < 20; j++) put(8'(j + 1));
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rx_data, rx_valid, rx_sof, rx_eof, rx_err, frame_done, rx_len, cnt_good, cnt_bad} !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs got d=%h v=%b len=%0d good=%0d bad=%0d want all 0", rx_data, rx_valid, rx_len, cnt_good, cnt_bad);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL mid_reset_bytes got pending=%0d want 0", exp_q.size());
            exp_q.delete();
        end
        exp_good = 0;
        exp_bad = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 20; j < 40; j++) put(8'(j + 1));
        idle(2);
        drain("after_reset_idle");
        send_frame(7, 64, 1'b0, 4);
        drain("after_reset_frame");
    endtask

    initial begin
        test_reset();
        test_good();
        test_runt();
        test_fcs();
        test_overlength();
        test_bad_preamble();
        test_short_frames();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
